// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported req/ack memory between instruction fetch and the data port.
// Define ARB_PERF_CNT_EN to add the perf_conflicts_o / perf_forced_o saturating counters.
module unified_mem_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       perf_conflicts_o,
    output logic [31:0]       perf_forced_o,
`endif
    input  logic              i_req_i,
    input  logic [AW-1:0]     i_addr_i,
    output logic [DW-1:0]     i_rdata_o,
    output logic              i_ready_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AW-1:0]     d_addr_i,
    input  logic [DW-1:0]     d_wdata_i,
    input  logic [DW/8-1:0]   d_wstrb_i,
    output logic [DW-1:0]     d_rdata_o,
    output logic              d_ready_o,
    output logic              m_req_o,
    output logic              m_we_o,
    output logic [AW-1:0]     m_addr_o,
    output logic [DW-1:0]     m_wdata_o,
    output logic [DW/8-1:0]   m_wstrb_o,
    input  logic [DW-1:0]     m_rdata_i,
    input  logic              m_ack_i
);

    localparam int unsigned SW   = DW / 8;
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StGntI,
        StGntD,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] starve_q, starve_d;
    logic            sel_d_q, sel_d_d;
    logic            m_req_q, m_req_d;
    logic            m_we_q, m_we_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_wdata_q, m_wdata_d;
    logic [SW-1:0]   m_wstrb_q, m_wstrb_d;
    logic [DW-1:0]   i_rdata_q, i_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            i_ready_q, i_ready_d;
    logic            d_ready_q, d_ready_d;

    logic            starve_max;
    logic            arb_en;
    logic            gnt_d;
    logic            gnt_i;

    assign starve_max = (starve_q == CntW'(STARVE_LIMIT));

    // The IDLE cycle carrying a ready pulse is a bubble: the finishing requester still
    // holds its req there, so no arbitration may happen in it.
    assign arb_en = (state_q == StIdle) && !i_ready_q && !d_ready_q;
    assign gnt_d  = arb_en && d_req_i && !(i_req_i && starve_max);
    assign gnt_i  = arb_en && i_req_i && !gnt_d;

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        sel_d_d   = sel_d_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gnt_d) begin
                    state_d   = StGntD;
                    sel_d_d   = 1'b1;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we_i;
                    m_addr_d  = d_addr_i;
                    m_wdata_d = d_wdata_i;
                    m_wstrb_d = d_wstrb_i;
                    // Only counts while a fetch is actually being passed over.
                    if (i_req_i) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (gnt_i) begin
                    state_d   = StGntI;
                    sel_d_d   = 1'b0;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = i_addr_i;
                    m_wdata_d = '0;
                    m_wstrb_d = '0;
                    starve_d  = '0;
                end
            end
            StGntI, StGntD: begin
                if (m_ack_i) begin
                    m_req_d = 1'b0;
                    state_d = StResp;
                    if (sel_d_q) begin
                        d_rdata_d = m_rdata_i;
                    end else begin
                        i_rdata_d = m_rdata_i;
                    end
                end
            end
            StResp: begin
                state_d   = StIdle;
                d_ready_d = sel_d_q;
                i_ready_d = !sel_d_q;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= StIdle;
            starve_q  <= '0;
            sel_d_q   <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            sel_d_q   <= sel_d_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
        end
    end

    assign m_req_o   = m_req_q;
    assign m_we_o    = m_we_q;
    assign m_addr_o  = m_addr_q;
    assign m_wdata_o = m_wdata_q;
    assign m_wstrb_o = m_wstrb_q;
    assign i_rdata_o = i_rdata_q;
    assign i_ready_o = i_ready_q;
    assign d_rdata_o = d_rdata_q;
    assign d_ready_o = d_ready_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_conflicts_q;
    logic [31:0] perf_forced_q;
    logic        conflict;
    logic        forced;

    // Bubble cycles are excluded: only cycles that actually arbitrate are counted.
    assign conflict = arb_en && i_req_i && d_req_i;
    assign forced   = conflict && gnt_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            perf_conflicts_q <= '0;
            perf_forced_q    <= '0;
        end else begin
            if (conflict && (perf_conflicts_q != '1)) begin
                perf_conflicts_q <= perf_conflicts_q + 32'd1;
            end
            if (forced && (perf_forced_q != '1)) begin
                perf_forced_q <= perf_forced_q + 32'd1;
            end
        end
    end

    assign perf_conflicts_o = perf_conflicts_q;
    assign perf_forced_o    = perf_forced_q;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: expected memory requests and ready responses are
// queued at issue time and checked by a negedge monitor against what the DUT presents.
module tb_unified_mem_arbiter;

    typedef struct {
        logic [31:0] rdata;
        bit          chk_rd;
        int          cyc0;
        int          lat;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          chk_wd;
    } mreq_t;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic [31:0] i_rdata_o;
    logic        i_ready_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_wstrb_i;
    logic [31:0] d_rdata_o;
    logic        d_ready_o;
    logic        m_req_o;
    logic        m_we_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_wstrb_o;
    logic [31:0] m_rdata_i;
    logic        m_ack_i;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_conflicts_o;
    logic [31:0] perf_forced_o;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    rsp_t  iq[$];
    rsp_t  dq[$];
    mreq_t mq[$];

    logic [31:0] mem_rd [logic [31:0]];
    int          ack_lat   = 1;
    bit          mem_hold  = 1'b0;
    int          ack_force = 0;

    unified_mem_arbiter #(
        .AW(32),
        .DW(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
`ifdef ARB_PERF_CNT_EN
        .perf_conflicts_o(perf_conflicts_o),
        .perf_forced_o   (perf_forced_o),
`endif
        .i_req_i   (i_req_i),
        .i_addr_i  (i_addr_i),
        .i_rdata_o (i_rdata_o),
        .i_ready_o (i_ready_o),
        .d_req_i   (d_req_i),
        .d_we_i    (d_we_i),
        .d_addr_i  (d_addr_i),
        .d_wdata_i (d_wdata_i),
        .d_wstrb_i (d_wstrb_i),
        .d_rdata_o (d_rdata_o),
        .d_ready_o (d_ready_o),
        .m_req_o   (m_req_o),
        .m_we_o    (m_we_o),
        .m_addr_o  (m_addr_o),
        .m_wdata_o (m_wdata_o),
        .m_wstrb_o (m_wstrb_o),
        .m_rdata_i (m_rdata_i),
        .m_ack_i   (m_ack_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: acks after ack_lat cycles of m_req, returns mem_rd[] or ~addr.
    initial begin
        int cnt  = 0;
        int done = 0;
        m_ack_i   = 1'b0;
        m_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            m_ack_i = 1'b0;
            if (ack_force > done) begin
                done++;
                m_ack_i   = 1'b1;
                m_rdata_i = 32'hBADC0DE5;
            end else if (m_req_o && !mem_hold) begin
                cnt++;
                if (cnt == ack_lat) begin
                    m_ack_i   = 1'b1;
                    m_rdata_i = mem_rd.exists(m_addr_o) ? mem_rd[m_addr_o] : ~m_addr_o;
                    cnt       = 0;
                end
            end else if (!m_req_o) begin
                cnt = 0;
            end
        end
    end

    // Monitor: memory-side request checks plus ready/rdata/latency scoreboard.
    initial begin
        bit    req_prev = 1'b0;
        mreq_t cur;
        rsp_t  r;
        cur = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, wstrb: 4'h0, chk_wd: 1'b0};
        forever begin
            @(negedge clk_i);
            if (reset_ni) begin
                if (m_req_o && !req_prev) begin
                    if (mq.size() == 0) begin
                        chk("m_req_unexpected", {31'h0, m_req_o}, 32'h0);
                    end else begin
                        cur = mq.pop_front();
                        chk("m_we", {31'h0, m_we_o}, {31'h0, cur.we});
                        chk("m_addr", m_addr_o, cur.addr);
                        chk("m_wstrb", {28'h0, m_wstrb_o}, {28'h0, cur.wstrb});
                        if (cur.chk_wd) chk("m_wdata", m_wdata_o, cur.wdata);
                    end
                end else if (m_req_o) begin
                    chk("m_addr_hold", m_addr_o, cur.addr);
                    chk("m_we_hold", {31'h0, m_we_o}, {31'h0, cur.we});
                    chk("m_wstrb_hold", {28'h0, m_wstrb_o}, {28'h0, cur.wstrb});
                    if (cur.chk_wd) chk("m_wdata_hold", m_wdata_o, cur.wdata);
                end
                if (i_ready_o) begin
                    if (iq.size() == 0) begin
                        chk("i_ready_unexpected", {31'h0, i_ready_o}, 32'h0);
                    end else begin
                        r = iq.pop_front();
                        chk("i_rdata", i_rdata_o, r.rdata);
                        chk("i_latency", cyc - r.cyc0, r.lat);
                    end
                end
                if (d_ready_o) begin
                    if (dq.size() == 0) begin
                        chk("d_ready_unexpected", {31'h0, d_ready_o}, 32'h0);
                    end else begin
                        r = dq.pop_front();
                        if (r.chk_rd) chk("d_rdata", d_rdata_o, r.rdata);
                        chk("d_latency", cyc - r.cyc0, r.lat);
                    end
                end
            end
            req_prev = m_req_o;
        end
    end

    task automatic push_m(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input bit chk_wd);
        mreq_t m;
        m = '{we: we, addr: addr, wdata: wdata, wstrb: wstrb, chk_wd: chk_wd};
        mq.push_back(m);
    endtask

    // Called at posedge+#1; leaves i_req low one edge after i_ready.
    task automatic do_i(input logic [31:0] addr, input logic [31:0] rdata, input int lat);
        rsp_t r;
        bit   seen = 1'b0;
        r = '{rdata: rdata, chk_rd: 1'b1, cyc0: cyc, lat: lat};
        iq.push_back(r);
        i_req_i  = 1'b1;
        i_addr_i = addr;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk_i);
            seen = i_ready_o;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL i_timeout: no i_ready for addr 0x%08h, required within 200 cycles", addr);
        end
        @(posedge clk_i);
        #1;
        i_req_i = 1'b0;
    endtask

    task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] rdata, input int lat,
                        input bit hold);
        rsp_t r;
        bit   seen = 1'b0;
        r = '{rdata: rdata, chk_rd: !we, cyc0: cyc, lat: lat};
        dq.push_back(r);
        d_req_i   = 1'b1;
        d_we_i    = we;
        d_addr_i  = addr;
        d_wdata_i = wdata;
        d_wstrb_i = wstrb;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk_i);
            seen = d_ready_o;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL d_timeout: no d_ready for addr 0x%08h, required within 200 cycles", addr);
        end
        @(posedge clk_i);
        #1;
        if (!hold) d_req_i = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk_i);
        #1;
        reset_ni = 1'b0;
        #3;
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_ni  = 1'b0;
        i_req_i   = 1'b0;
        i_addr_i  = '0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_addr_i  = '0;
        d_wdata_i = '0;
        d_wstrb_i = '0;
        mem_rd[32'h0000_0100] = 32'h0050_0093;
        mem_rd[32'h0000_2004] = 32'h1234_5678;
        mem_rd[32'h0000_0040] = 32'h0000_0013;
        mem_rd[32'h0000_0010] = 32'h0000_0297;
        for (int k = 0; k < 5; k++) mem_rd[32'h3000 + 4 * k] = 32'h1000_0000 + k;

        // Reset values.
        repeat (2) @(negedge clk_i);
        chk("rst_m_req", {31'h0, m_req_o}, 32'h0);
        chk("rst_m_we", {31'h0, m_we_o}, 32'h0);
        chk("rst_m_addr", m_addr_o, 32'h0);
        chk("rst_m_wdata", m_wdata_o, 32'h0);
        chk("rst_m_wstrb", {28'h0, m_wstrb_o}, 32'h0);
        chk("rst_i_ready", {31'h0, i_ready_o}, 32'h0);
        chk("rst_d_ready", {31'h0, d_ready_o}, 32'h0);
        chk("rst_i_rdata", i_rdata_o, 32'h0);
        chk("rst_d_rdata", d_rdata_o, 32'h0);
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single fetch, ack latency 1: ready 3 cycles after request.
        ack_lat = 1;
        push_m(1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
        do_i(32'h100, 32'h0050_0093, 3);
        repeat (2) @(posedge clk_i);
        #1;

        // Store with ack latency 4: ready 6 cycles after request.
        ack_lat = 4;
        push_m(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF, 1'b1);
        do_d(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF, 32'h0, 6, 1'b0);

        // Load with ack latency 2.
        ack_lat = 2;
        push_m(1'b0, 32'h2004, 32'hA5A5_A5A5, 4'h3, 1'b1);
        do_d(1'b0, 32'h2004, 32'hA5A5_A5A5, 4'h3, 32'h1234_5678, 4, 1'b0);

        // Starvation: four data grants, then a forced fetch, then the pending data access.
        pulse_reset();
        ack_lat = 1;
        for (int k = 0; k < 4; k++) push_m(1'b0, 32'h3000 + 4 * k, 32'h0, 4'hF, 1'b1);
        push_m(1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
        push_m(1'b0, 32'h3010, 32'h0, 4'hF, 1'b1);
        fork
            begin
                for (int k = 0; k < 4; k++)
                    do_d(1'b0, 32'h3000 + 4 * k, 32'h0, 4'hF, 32'h1000_0000 + k, 3, 1'b1);
                do_d(1'b0, 32'h3010, 32'h0, 4'hF, 32'h1000_0004, 7, 1'b0);
            end
            do_i(32'h40, 32'h0000_0013, 19);
        join
`ifdef ARB_PERF_CNT_EN
        chk("perf_forced", perf_forced_o, 32'd1);
        chk("perf_conflicts", perf_conflicts_o, 32'd5);
`endif
        repeat (2) @(posedge clk_i);
        #1;

        // Simultaneous requests: data first, fetch in the IDLE cycle after d_ready.
        push_m(1'b0, 32'h3000, 32'h0, 4'hF, 1'b1);
        push_m(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        fork
            do_d(1'b0, 32'h3000, 32'h0, 4'hF, 32'h1000_0000, 3, 1'b0);
            do_i(32'h10, 32'h0000_0297, 7);
        join
        repeat (2) @(posedge clk_i);
        #1;

        // Reset while granted to data, then a stray ack after release.
        mem_hold = 1'b1;
        push_m(1'b1, 32'h5000, 32'h0BAD_F00D, 4'hF, 1'b1);
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h5000;
        d_wdata_i = 32'h0BAD_F00D;
        d_wstrb_i = 4'hF;
        repeat (2) @(negedge clk_i);
        chk("gnt_m_req", {31'h0, m_req_o}, 32'h1);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("midrst_m_req", {31'h0, m_req_o}, 32'h0);
        chk("midrst_m_addr", m_addr_o, 32'h0);
        chk("midrst_d_ready", {31'h0, d_ready_o}, 32'h0);
        d_req_i = 1'b0;
        d_we_i  = 1'b0;
        @(negedge clk_i);
        #2;
        reset_ni  = 1'b1;
        ack_force = 1;
        repeat (5) begin
            @(negedge clk_i);
            chk("postrst_m_req", {31'h0, m_req_o}, 32'h0);
        end
        mem_hold = 1'b0;
        @(posedge clk_i);
        #1;

        // Arbiter must be back in IDLE: a fresh fetch has minimum latency.
        ack_lat = 1;
        push_m(1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
        do_i(32'h100, 32'h0050_0093, 3);
        repeat (3) @(posedge clk_i);

        chk("iq_drained", iq.size(), 32'd0);
        chk("dq_drained", dq.size(), 32'd0);
        chk("mq_drained", mq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port (read-only) and its MEM-stage data port (read/write).
- Memory side is a variable-latency req/ack interface.
- Each requester sees a request/ready handshake. The pipeline's hazard logic stalls a stage while that stage's req is high and its ready is low.
- Data port normally has priority. A starvation counter guarantees instruction fetch makes forward progress.

Parameters:
- AW, 32, address width of all ports
- DW, 32, data width of all ports
- STARVE_LIMIT, 4, consecutive data grants allowed while i_req waits before instruction fetch is forced a grant (must be >= 1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- i_req  input  1  instruction fetch request; held with i_addr stable until i_ready
- i_addr  input  AW  fetch address
- i_rdata  output  DW  fetch data, valid while i_ready=1
- i_ready  output  1  one-cycle pulse: fetch complete
- d_req  input  1  data request; held with d_we/d_addr/d_wdata/d_wstrb stable until d_ready
- d_we  input  1  1 = store, 0 = load
- d_addr  input  AW  data address
- d_wdata  input  DW  store data
- d_wstrb  input  DW/8  byte enables for stores
- d_rdata  output  DW  load data, valid while d_ready=1 (undefined for stores)
- d_ready  output  1  one-cycle pulse: data access complete
- m_req  output  1  memory request, held until m_ack
- m_we  output  1  memory write enable
- m_addr  output  AW  memory address
- m_wdata  output  DW  memory write data
- m_wstrb  output  DW/8  memory byte enables
- m_rdata  input  DW  memory read data, valid in the m_ack cycle
- m_ack  input  1  one-cycle completion pulse; earliest one cycle after m_req rises

Behaviour:
- States: IDLE, GNT_I, GNT_D, RESP. All outputs are registered.
- Reset (asynchronous, active-low):
  - state=IDLE; starve_cnt=0
  - m_req, m_we, i_ready, d_ready = 0
  - m_addr, m_wdata, m_wstrb, i_rdata, d_rdata = 0
- IDLE grant decision:
  - d_req and i_req, with starve_cnt < STARVE_LIMIT: grant D and increment starve_cnt.
  - i_req with (no d_req or starve_cnt == STARVE_LIMIT): grant I and clear starve_cnt.
  - d_req alone: grant D; starve_cnt is unchanged (it counts only while i_req is waiting).
  - No request: stay in IDLE; m_req=0.
- Grant effects:
  - The grant edge latches the winner's address, we, wdata and wstrb onto the m_* outputs.
  - m_req rises the next cycle (state GNT_x).
  - Instruction grants force m_we=0 and m_wstrb=0.
- GNT_x: hold all m_* outputs stable until m_ack. On m_ack, latch m_rdata into the granted port's rdata, drop m_req, and go to RESP.
- RESP: pulse the granted port's ready for exactly one cycle, then go to IDLE. The other port's ready stays 0.
- Minimum request-to-ready latency is 3 cycles (grant edge, m_ack in first GNT cycle, RESP). With memory ack latency L, the latency is L+2.
- A requester may present a new request at the edge ending its ready cycle. That request is arbitrated in the next IDLE cycle, so there is a one-cycle IDLE bubble between transactions.
- A req that drops before being granted is ignored. A req that drops mid-grant is a protocol violation; the transaction still completes and ready still pulses.
- m_ack outside GNT_x is ignored.
- starve_cnt saturates at STARVE_LIMIT.
- Reset mid-transaction: immediate return to IDLE with m_req=0. A late m_ack after reset is ignored.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds output port perf_conflicts (32 bits): counts IDLE cycles in which i_req and d_req are both high. Saturates at 0xFFFFFFFF; cleared by reset.
  - Adds output port perf_forced (32 bits): counts instruction grants forced by the starvation limit. Same saturation and reset rules.
- Undefined: both ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, memory ack 1 cycle after m_req with m_rdata=0x00500093 -> m_addr=0x100, m_we=0; i_ready pulses once, 3 cycles after request, with i_rdata=0x00500093; d_ready stays 0.
- Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0xF, ack latency 4 -> m_* hold those values for 4 cycles; d_ready pulses 6 cycles after request.
- Simultaneous: i_req and d_req both high, addr 0x10 / 0x3000 -> data granted first; fetch is granted in the IDLE cycle after d_ready.
- Starvation: d_req held high continuously and i_req=1, STARVE_LIMIT=4 -> four data grants, then one fetch grant; starve_cnt returns to 0.
- Reset mid-grant: assert reset in GNT_D before m_ack, then pulse m_ack after release -> m_req=0 immediately; no ready pulses; state IDLE.
- With ARB_PERF_CNT_EN: run the starvation scenario -> perf_forced=1; perf_conflicts equals the number of IDLE cycles with both requests high (5).
